// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD refresh block.
// Holds the HD44780 command bytes, the line geometry, and the state encodings
// of the top sequencer and the byte writer. It also holds a helper that maps
// an init step to its command byte.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38; // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C; // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01; // clear display (slow command)
  localparam logic [7:0] CMD_ENTRY    = 8'h06; // increment, no shift
  localparam logic [7:0] CMD_LINE1    = 8'h80; // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2    = 8'hC0; // DDRAM address 0x40
  localparam logic [7:0] CHAR_BLANK   = 8'h20;
  localparam int         LINE_LEN     = 16;

  typedef enum logic [2:0] {
    ST_POWERUP,   // kick off the power-up wait
    ST_PWR_WAIT,  // waiting for the power-up delay
    ST_INIT,      // init command in flight
    ST_LINE_CMD,  // line address command in flight
    ST_FETCH,     // present position to RAM
    ST_RDWAIT,    // RAM registers the read
    ST_LATCH,     // hand RAM data to the writer
    ST_CHAR       // character transfer in flight
  } lcd_state_e;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_WAIT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } wr_state_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// HD44780 byte transfer engine: SETUP (1 cycle) -> PULSE (EN_CYCLES, en=1)
// -> HOLD (CMD_CYCLES, or CLEAR_CYCLES when long_wait). rs/data are captured
// on start and held until the next start.
// It also provides a plain timed wait (wait_start), so that one down-counter
// times every delay in the block, including the power-up delay.
// Ports:
//   clock, reset (async, active low)
//   start, rs, byte_in, long_wait : launch a transfer (accepted when idle or
//                                   in the final wait/hold cycle)
//   wait_start                    : launch a POWERUP_CYCLES wait
//   done                          : 1-cycle pulse in the last wait/hold cycle
//   lcd_data, lcd_rs, lcd_en      : LCD pins
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 1000000,
  parameter int EN_CYCLES      = 25,
  parameter int CMD_CYCLES     = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       wait_start,
  input  logic       rs,
  input  logic [7:0] byte_in,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int MAX_A   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int MAX_B   = (EN_CYCLES > CMD_CYCLES) ? EN_CYCLES : CMD_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             long_q, long_d;
  logic             en_q, en_d;
  logic             idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    done    = 1'b0;
    idle    = 1'b0;
    unique case (state_q)
      WR_IDLE: idle = 1'b1;
      WR_WAIT, WR_HOLD: begin
        if (cnt_q == '0) begin
          done = 1'b1;
          idle = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_W'(EN_CYCLES - 1);
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
          cnt_d   = long_q ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(CMD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = WR_IDLE;
    endcase
    // Accepting a new request in the last hold cycle keeps back-to-back
    // commands at exactly 1 + EN_CYCLES + hold cycles each.
    if (idle) begin
      state_d = WR_IDLE;
      if (start) begin
        state_d = WR_SETUP;
        data_d  = byte_in;
        rs_d    = rs;
        long_d  = long_wait;
      end else if (wait_start) begin
        state_d = WR_WAIT;
        cnt_d   = CNT_W'(POWERUP_CYCLES - 1);
      end
    end
    en_d = (state_d == WR_PULSE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WR_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      en_q    <= en_d;
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;

endmodule

// File: rtl/lcd_refresh.sv
// 16x2 HD44780 refresher. After power-up init it endlessly copies the
// 32-entry character RAM to the display: positions 0-15 onto line 1 and
// 16-31 onto line 2.
// Ports:
//   clock, reset (async, active low); clock also clocks the RAM read port
//   lcdPosRead / dataRead : RAM read address / registered read data
//   lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on : LCD pins (write-only)
//   init_done  : high once init completes, until reset
//   frame_done : 1-cycle pulse after character 31's hold
module lcd_refresh
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BITS_SIZE      = 5,
  parameter int POWERUP_CYCLES = 1000000,
  parameter int EN_CYCLES      = 25,
  parameter int CMD_CYCLES     = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [BITS_SIZE-1:0]  lcdPosRead,
  input  logic [DATA_WIDTH-1:0] dataRead,
  output logic [7:0]            lcd_data,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_en,
  output logic                  lcd_on,
  output logic                  init_done,
  output logic                  frame_done
);

  localparam logic [BITS_SIZE-1:0] LINE1_LAST = BITS_SIZE'(LINE_LEN - 1);
  localparam logic [BITS_SIZE-1:0] FRAME_LAST = '1;

  lcd_state_e           state_q, state_d;
  logic [BITS_SIZE-1:0] pos_q, pos_d;
  logic [BITS_SIZE-1:0] addr_q, addr_d;
  logic [1:0]           idx_q, idx_d;
  logic                 init_done_q, init_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 on_q, on_d;

  logic       wr_start, wr_wait, wr_rs, wr_done, wr_long;
  logic [7:0] wr_byte;

  // Only the clear command needs the long settle time.
  assign wr_long = !wr_rs && (wr_byte == CMD_CLEAR);

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    on_d         = 1'b1;
    wr_start     = 1'b0;
    wr_wait      = 1'b0;
    wr_rs        = 1'b0;
    wr_byte      = 8'h00;
    unique case (state_q)
      ST_POWERUP: begin
        wr_wait = 1'b1;
        state_d = ST_PWR_WAIT;
      end
      ST_PWR_WAIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          wr_byte  = init_cmd(2'd0);
          idx_d    = 2'd0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
            wr_byte     = CMD_LINE1;
            pos_d       = '0;
            state_d     = ST_LINE_CMD;
          end else begin
            idx_d   = idx_q + 2'd1;
            wr_byte = init_cmd(idx_q + 2'd1);
          end
        end
      end
      ST_LINE_CMD: begin
        if (wr_done) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        addr_d  = pos_q;
        state_d = ST_RDWAIT;
      end
      ST_RDWAIT: state_d = ST_LATCH;
      ST_LATCH: begin
        // The writer captures the byte on this edge, so each character is
        // whatever the RAM held at its own read, not a frame snapshot.
        wr_start = 1'b1;
        wr_rs    = 1'b1;
        wr_byte  = dataRead;
        state_d  = ST_CHAR;
      end
      ST_CHAR: begin
        if (wr_done) begin
          pos_d = pos_q + BITS_SIZE'(1);
          if (pos_q == FRAME_LAST) begin
            frame_done_d = 1'b1;
            wr_start     = 1'b1;
            wr_byte      = CMD_LINE1;
            state_d      = ST_LINE_CMD;
          end else if (pos_q == LINE1_LAST) begin
            wr_start = 1'b1;
            wr_byte  = CMD_LINE2;
            state_d  = ST_LINE_CMD;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_POWERUP;
      pos_q        <= '0;
      addr_q       <= '0;
      idx_q        <= 2'd0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      on_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      on_q         <= on_d;
    end
  end

  lcd_byte_writer #(
    .POWERUP_CYCLES(POWERUP_CYCLES),
    .EN_CYCLES     (EN_CYCLES),
    .CMD_CYCLES    (CMD_CYCLES),
    .CLEAR_CYCLES  (CLEAR_CYCLES)
  ) u_writer (
    .clock     (clock),
    .reset     (reset),
    .start     (wr_start),
    .wait_start(wr_wait),
    .rs        (wr_rs),
    .byte_in   (wr_byte),
    .long_wait (wr_long),
    .done      (wr_done),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en)
  );

  assign lcdPosRead = addr_q;
  assign lcd_rw     = 1'b0;
  assign lcd_on     = on_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh.sv
// Bench for lcd_refresh with short timing parameters. A pin monitor turns LCD
// bus activity into a list of transfers and checks pulse width, setup and hold
// stability, and that lcd_rw stays low. The main sequence compares that list
// with a byte stream derived from the RAM contents the bench itself wrote.
module tb_lcd_refresh;
  localparam int P_PWR = 20, P_EN = 2, P_CMD = 4, P_CLR = 10;
  localparam int FRAME_LEN = 34;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] pos_rd;
  logic [7:0] data_rd, lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, init_done, frame_done;
  logic [7:0] mem [32];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) data_rd <= mem[pos_rd];

  lcd_refresh #(
    .DATA_WIDTH(8), .BITS_SIZE(5), .POWERUP_CYCLES(P_PWR),
    .EN_CYCLES(P_EN), .CMD_CYCLES(P_CMD), .CLEAR_CYCLES(P_CLR)
  ) dut (
    .clock(clk), .reset(rst_n), .lcdPosRead(pos_rd), .dataRead(data_rd),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .init_done(init_done), .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- pin monitor ----------------
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;    // low cycles since previous falling edge (incl. setup)
    logic [4:0] pos;    // lcdPosRead seen when lcd_en rose
    logic       idone;
  } xfer_t;
  xfer_t xq[$];

  logic       m_prev_en, m_prev_rs, m_prev_fd;
  logic [7:0] m_prev_d;
  int         m_low, m_hi, m_hold, fd_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_prev_en = 1'b0; m_prev_rs = 1'b0; m_prev_fd = 1'b0; m_prev_d = 8'h00;
      m_low = 0; m_hi = 0; m_hold = 0;
    end else begin
      chk("rw_low", lcd_rw, 1'b0);
      if (lcd_en && !m_prev_en) begin
        chk("setup_stable", {lcd_rs, lcd_data}, {m_prev_rs, m_prev_d});
        xq.push_back('{lcd_rs, lcd_data, m_low, pos_rd, init_done});
        m_hi = 1;
      end else if (lcd_en) begin
        chk("pulse_stable", {lcd_rs, lcd_data}, {m_prev_rs, m_prev_d});
        m_hi++;
      end else if (m_prev_en) begin
        chk("pulse_width", m_hi, P_EN);
        m_hold = (!lcd_rs && lcd_data == 8'h01) ? P_CLR : P_CMD;
        m_low  = 1;
      end else begin
        if ({lcd_rs, lcd_data} !== {m_prev_rs, m_prev_d})
          chk("hold_time", (m_low >= m_hold), 1'b1);
        m_low++;
      end
      if (frame_done) begin
        chk("frame_done_width", m_prev_fd, 1'b0);
        if (!m_prev_fd) begin
          fd_cnt++;
          if (xq.size() > 0) chk("frame_done_after_pos31", {xq[$].rs, xq[$].pos}, {1'b1, 5'd31});
        end
      end
      m_prev_en = lcd_en; m_prev_rs = lcd_rs; m_prev_d = lcd_data; m_prev_fd = frame_done;
    end
  end

  // ---------------- reference model helpers ----------------
  task automatic wait_n(input int n);
    int t = 0;
    while (xq.size() < n) begin
      @(negedge clk); #1;
      t++;
      if (t > 5000) begin
        checks++; errors++;
        $display("FAIL wait_xfer actual=%0d required=%0d", xq.size(), n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  // Expected gap follows the byte period rule: previous byte's hold, plus
  // the setup cycle, plus the three fetch cycles when the next byte is a character.
  int e_prev_hold;
  task automatic exp_byte(input int k, input logic rs, input logic [7:0] d, input int pos);
    chk($sformatf("byte%0d", k), {xq[k].rs, xq[k].data}, {rs, d});
    if (e_prev_hold >= 0) chk($sformatf("gap%0d", k), xq[k].gap, e_prev_hold + (rs ? 4 : 1));
    if (pos >= 0) chk($sformatf("pos%0d", k), xq[k].pos, pos);
    e_prev_hold = (!rs && d == 8'h01) ? P_CLR : P_CMD;
  endtask

  typedef struct { logic rs; logic [7:0] data; } init_vec_t;
  init_vec_t init_tab[4];

  // Per frame: RAM edits before the frame, a mid-frame poke of position 5
  // (1 = just before its fetch, 2 = just after its latch), and the byte
  // that must appear at position 5 in that frame.
  typedef struct {
    logic       rand_fill;  // randomise every position except 5
    logic       set5;
    logic [7:0] set5_val;
    int         poke;
    logic [7:0] poke_val;
    logic [7:0] exp5;
  } frame_vec_t;
  frame_vec_t frame_tab[5];

  task automatic run_init();
    wait_n(4);
    checks++;
    if (xq[0].gap < P_PWR + 1 || xq[0].gap > P_PWR + 3) begin
      errors++;
      $display("FAIL powerup_gap actual=%0d required=%0d..%0d", xq[0].gap, P_PWR + 1, P_PWR + 3);
    end
    e_prev_hold = -1;
    for (int k = 0; k < 4; k++) exp_byte(k, init_tab[k].rs, init_tab[k].data, -1);
    wait_n(5);
    chk("init_done_before", xq[3].idone, 1'b0);
    chk("init_done_after", xq[4].idone, 1'b1);
  endtask

  logic [7:0] expf [32];

  initial begin
    init_tab[0] = '{1'b0, 8'h38};
    init_tab[1] = '{1'b0, 8'h0C};
    init_tab[2] = '{1'b0, 8'h01};
    init_tab[3] = '{1'b0, 8'h06};
    frame_tab[0] = '{1'b0, 1'b0, 8'h00, 0, 8'h00, 8'h46};
    frame_tab[1] = '{1'b0, 1'b1, 8'h35, 1, 8'h7A, 8'h7A};
    frame_tab[2] = '{1'b0, 1'b1, 8'h35, 2, 8'h7A, 8'h35};
    frame_tab[3] = '{1'b1, 1'b0, 8'h00, 0, 8'h00, 8'h7A};
    frame_tab[4] = '{1'b1, 1'b1, 8'h00, 0, 8'h00, 8'h00};
    frame_tab[4].set5_val = 8'($urandom);
    frame_tab[4].exp5     = frame_tab[4].set5_val;
    for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_lcd_data", lcd_data, 8'h00);
    chk("rst_rs_rw_en", {lcd_rs, lcd_rw, lcd_en}, 3'b000);
    chk("rst_lcd_on", lcd_on, 1'b0);
    chk("rst_pos", pos_rd, 5'd0);
    chk("rst_flags", {init_done, frame_done}, 2'b00);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("lcd_on_after_release", lcd_on, 1'b1);

    run_init();

    for (int f = 0; f < 5; f++) begin
      int base;
      base = 4 + f * FRAME_LEN;
      if (frame_tab[f].rand_fill)
        for (int p = 0; p < 32; p++) if (p != 5) mem[p] = 8'($urandom);
      if (frame_tab[f].set5) mem[5] = frame_tab[f].set5_val;
      for (int p = 0; p < 32; p++) expf[p] = mem[p];
      expf[5] = frame_tab[f].exp5;
      if (frame_tab[f].poke == 1) begin
        wait_n(base + 6);                       // char 4 enable rose
        repeat (P_EN - 1 + P_CMD) @(negedge clk); // last hold cycle of char 4
        mem[5] = frame_tab[f].poke_val;
      end else if (frame_tab[f].poke == 2) begin
        wait_n(base + 7);                       // char 5 already latched
        mem[5] = frame_tab[f].poke_val;
      end
      wait_n(base + FRAME_LEN);
      exp_byte(base, 1'b0, 8'h80, -1);
      for (int p = 0; p < 32; p++) begin
        if (p == 16) exp_byte(base + 17, 1'b0, 8'hC0, -1);
        exp_byte(base + 1 + p + (p >= 16 ? 1 : 0), 1'b1, expf[p], p);
      end
    end

    // byte after the last frame is the line-1 command again, not an init command
    wait_n(4 + 5 * FRAME_LEN + 1);
    exp_byte(4 + 5 * FRAME_LEN, 1'b0, 8'h80, -1);
    chk("frame_done_count", fd_cnt, 5);

    // asynchronous reset during the enable pulse of character 10
    wait_n(4 + 5 * FRAME_LEN + 12);
    chk("pre_reset_pos", xq[4 + 5 * FRAME_LEN + 11].pos, 5'd10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_en", lcd_en, 1'b0);
    chk("midrst_on", lcd_on, 1'b0);
    chk("midrst_pos", pos_rd, 5'd0);
    chk("midrst_init_done", init_done, 1'b0);
    chk("midrst_data_rs", {lcd_rs, lcd_data}, 9'h000);
    repeat (2) @(negedge clk);
    xq.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("lcd_on_after_rerelease", lcd_on, 1'b1);
    run_init();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
